// File: rtl/spi_reg_writer.sv
// Purpose: SPI mode-0 write-only slave that commits 16-bit frames into five 8-bit PWM config registers.
// Latency: register update and wr_commit pulse land SYNC_STAGES+2 clk edges after the pin-level ncs rise.
// Backpressure: none; the controller must respect the SPI timing limits, frames are never stalled.
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   sclk, ncs, copi      asynchronous SPI pins (mode 0, MSB first, ncs active-low)
//   en_reg_out_7_0 ..    five configuration registers at addresses 0x00..0x04
//   pwm_duty_cycle
//   wr_commit            one-cycle pulse per accepted write frame
module spi_reg_writer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_commit
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   sclk_hist;
    logic                   ncs_hist;

    // Marks when the ncs chain and its history flop hold real pin samples
    // rather than reset values. Without it, a pin already low at reset
    // release would look like a fresh falling edge and start a bogus frame.
    logic [SYNC_STAGES:0]   sync_fill;

    logic [1:0]  state;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;

    logic sclk_s;
    logic ncs_s;
    logic copi_s;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;
    logic frame_ok;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ncs_fall  = ~ncs_s & ncs_hist & sync_fill[SYNC_STAGES];
    assign ncs_rise  = ncs_s & ~ncs_hist;

    assign frame_ok = (bit_cnt == CNT_FULL) && shift_reg[15] && (shift_reg[14:8] <= 7'h04);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            copi_sync <= '0;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
            sync_fill <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            sclk_hist <= sclk_s;
            ncs_hist  <= ncs_s;
            sync_fill <= {sync_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state     <= RECV;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                RECV: begin
                    // The ncs rise wins: an sclk edge in the same cycle belongs
                    // to no frame and is dropped.
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && !ncs_s) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_commit       <= 1'b0;
        end else begin
            wr_commit <= 1'b0;
            if (state == COMMIT && frame_ok) begin
                wr_commit <= 1'b1;
                // Address range already limited to 0..4 by frame_ok.
                case (shift_reg[10:8])
                    3'd0:    en_reg_out_7_0  <= shift_reg[7:0];
                    3'd1:    en_reg_out_15_8 <= shift_reg[7:0];
                    3'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
                    3'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
                    3'd4:    pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
